// File: rtl/secded_mem_engine.sv
// SECDED (extended Hamming) memory engine: reads NUM_WORDS codewords from byte memory,
// corrects single-bit errors, flags double errors and writes flagged data words back.
module secded_mem_engine #(
   parameter int K         = 11,
   parameter int NUM_WORDS = 15,
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wdata,
   output logic [7:0]        n_single,
   output logic [7:0]        n_double
);

   function automatic int calc_r(int k);
      int r;
      r = 1;
      while ((1 << r) < k + r + 1) r++;
      return r;
   endfunction

   // Codeword bit position of data bit j: skips p0 and every power-of-two position.
   function automatic int data_pos(int j);
      int cnt;
      cnt = 0;
      for (int i = 3; i < 64; i++) begin
         if ((i & (i - 1)) != 0) begin
            if (cnt == j) return i;
            cnt++;
         end
      end
      return 0;
   endfunction

   localparam int R         = calc_r(K);
   localparam int N         = K + R + 1;
   localparam int BYTES     = (N + 7) / 8;
   localparam int CW_W      = 8 * BYTES;
   localparam logic [3:0] LAST_BYTE = 4'(BYTES - 1);
   localparam logic [7:0] LAST_WORD = 8'(NUM_WORDS - 1);

   typedef enum logic [2:0] {IDLE, RD, DEC, WR, DONE} state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d, rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [7:0]        wdata_q, wdata_d, ns_q, ns_d, nd_q, nd_d, word_q, word_d;
   logic [3:0]        byte_q, byte_d;
   logic [CW_W-1:0]   cw_q, cw_d, res_q, res_d;

   logic [CW_W-1:0]   cw_full, cw_fix, res_dec;
   logic [K-1:0]      data_dec;
   logic [6:0]        syn;
   logic              par, err_single, err_double;

   // The last byte is still on mem_rdata during DEC, so decode straight from the bus.
   always_comb begin
      cw_full = cw_q;
      cw_full[CW_W-1 -: 8] = mem_rdata;
      syn = '0;
      par = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (cw_full[i]) begin
            par = ~par;
            syn = syn ^ 7'(i);
         end
      end
      err_single = par && (syn < 7'(N));
      err_double = (par && (syn >= 7'(N))) || (!par && (syn != 7'd0));
      cw_fix = cw_full;
      for (int i = 0; i < N; i++) begin
         if (err_single && (syn == 7'(i))) cw_fix[i] = ~cw_full[i];
      end
      for (int j = 0; j < K; j++) data_dec[j] = cw_fix[data_pos(j)];
      res_dec = '0;
      res_dec[K-1:0] = data_dec;
      res_dec[CW_W-1] = err_double;
      res_dec[CW_W-2] = err_single;
   end

   always_comb begin
      // NOTE: every _d starts from its _q (strobes from 0) so no path through the case infers a latch.
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = done_q;
      rd_en_d  = 1'b0;
      wr_en_d  = 1'b0;
      addr_d   = addr_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      wdata_d  = wdata_q;
      ns_d     = ns_q;
      nd_d     = nd_q;
      word_d   = word_q;
      byte_d   = byte_q;
      cw_d     = cw_q;
      res_d    = res_q;

      for (int b = 0; b < BYTES - 1; b++) begin
         if (state_q == RD && byte_q == 4'(b + 1)) cw_d[8*b +: 8] = mem_rdata;
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RD;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               ns_d     = '0;
               nd_d     = '0;
               word_d   = '0;
               byte_d   = '0;
               rd_en_d  = 1'b1;
               addr_d   = ADDR_W'(SRC_BASE);
               rd_ptr_d = ADDR_W'(SRC_BASE + 1);
               wr_ptr_d = ADDR_W'(DST_BASE);
            end
         end
         RD: begin
            if (byte_q == LAST_BYTE) begin
               state_d = DEC;
               byte_d  = '0;
            end else begin
               byte_d   = byte_q + 4'd1;
               rd_en_d  = 1'b1;
               addr_d   = rd_ptr_q;
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
         end
         DEC: begin
            res_d = res_dec;
            if (err_single && ns_q != 8'hFF) ns_d = ns_q + 8'd1;
            if (err_double && nd_q != 8'hFF) nd_d = nd_q + 8'd1;
            state_d  = WR;
            byte_d   = '0;
            wr_en_d  = 1'b1;
            addr_d   = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            wdata_d  = res_dec[7:0];
         end
         WR: begin
            if (byte_q == LAST_BYTE) begin
               byte_d = '0;
               if (word_q == LAST_WORD) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d  = RD;
                  word_d   = word_q + 8'd1;
                  rd_en_d  = 1'b1;
                  addr_d   = rd_ptr_q;
                  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               end
            end else begin
               byte_d   = byte_q + 4'd1;
               wr_en_d  = 1'b1;
               addr_d   = wr_ptr_q;
               wr_ptr_d = wr_ptr_q + ADDR_W'(1);
               for (int b = 1; b < BYTES; b++) begin
                  if (byte_q == 4'(b - 1)) wdata_d = res_q[8*b +: 8];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         wr_en_q  <= 1'b0;
         addr_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         wdata_q  <= '0;
         ns_q     <= '0;
         nd_q     <= '0;
         word_q   <= '0;
         byte_q   <= '0;
         cw_q     <= '0;
         res_q    <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rd_en_q  <= rd_en_d;
         wr_en_q  <= wr_en_d;
         addr_q   <= addr_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         wdata_q  <= wdata_d;
         ns_q     <= ns_d;
         nd_q     <= nd_d;
         word_q   <= word_d;
         byte_q   <= byte_d;
         cw_q     <= cw_d;
         res_q    <= res_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign mem_addr  = addr_q;
   assign mem_rd_en = rd_en_q;
   assign mem_wr_en = wr_en_q;
   assign mem_wdata = wdata_q;
   assign n_single  = ns_q;
   assign n_double  = nd_q;

endmodule

// File: tb/tb_secded_mem_engine.sv
// Bench for secded_mem_engine: three instances (K=11 x1 word, K=11 x15 words, K=26 x4 words),
// each with its own byte memory, checked against an encoder/injected-error model.
module tb_secded_mem_engine;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst [3];
   logic       start [3];
   logic       busy [3];
   logic       done [3];
   logic       rd_en [3];
   logic       wr_en [3];
   logic [7:0] addr [3];
   logic [7:0] rdata [3];
   logic [7:0] wdata [3];
   logic [7:0] ns [3];
   logic [7:0] nd [3];

   logic [7:0] mem [3][256];
   logic [7:0] exp_mem [3][256];
   bit         allow_wr [3];

   int n_checks = 0;
   int n_fail   = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      secded_mem_engine #(
         .K(g == 2 ? 26 : 11),
         .NUM_WORDS(g == 0 ? 1 : (g == 1 ? 15 : 4)),
         .SRC_BASE(30),
         .DST_BASE(0),
         .ADDR_W(8)
      ) u_dut (
         .clk(clk),
         .reset(rst[g]),
         .start(start[g]),
         .busy(busy[g]),
         .done(done[g]),
         .mem_addr(addr[g]),
         .mem_rd_en(rd_en[g]),
         .mem_rdata(rdata[g]),
         .mem_wr_en(wr_en[g]),
         .mem_wdata(wdata[g]),
         .n_single(ns[g]),
         .n_double(nd[g])
      );
   end

   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (wr_en[g]) mem[g][addr[g]] <= wdata[g];
         if (rd_en[g]) rdata[g] <= mem[g][addr[g]];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic int cfg_k(int g);
      return (g == 2) ? 26 : 11;
   endfunction

   function automatic int cfg_nw(int g);
      return (g == 0) ? 1 : ((g == 1) ? 15 : 4);
   endfunction

   function automatic int calc_r(int k);
      int r;
      r = 1;
      while ((1 << r) < k + r + 1) r++;
      return r;
   endfunction

   function automatic int calc_n(int k);
      return k + calc_r(k) + 1;
   endfunction

   function automatic int calc_b(int k);
      return (calc_n(k) + 7) / 8;
   endfunction

   function automatic bit is_pow2(int i);
      return (i & (i - 1)) == 0;
   endfunction

   // Encoder: scatter data, then choose each parity bit so its group has even parity.
   function automatic logic [63:0] encode(logic [63:0] d, int k);
      logic [63:0] cw;
      logic        par;
      int          n;
      int          j;
      n  = calc_n(k);
      j  = 0;
      cw = '0;
      for (int i = 1; i < n; i++) begin
         if (!is_pow2(i)) begin
            cw[i] = d[j];
            j++;
         end
      end
      for (int p = 1; p < n; p = p * 2) begin
         par = 1'b0;
         for (int i = 1; i < n; i++) if ((i & p) != 0 && i != p) par ^= cw[i];
         cw[p] = par;
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   function automatic logic [63:0] extract(logic [63:0] cw, int k);
      logic [63:0] d;
      int          j;
      d = '0;
      j = 0;
      for (int i = 1; i < calc_n(k); i++) begin
         if (!is_pow2(i)) begin
            d[j] = cw[i];
            j++;
         end
      end
      return d;
   endfunction

   // Expected result from knowledge of how many bits were injected.
   function automatic logic [63:0] expect_result(logic [63:0] d, logic [63:0] cw_err, int flips, int k);
      int w;
      w = 8 * calc_b(k);
      if (flips == 0) return d;
      if (flips == 1) return d | (64'd1 << (w - 2));
      return extract(cw_err, k) | (64'd1 << (w - 1));
   endfunction

   task automatic load_word(input int g, input int idx, input logic [63:0] cw, input logic [63:0] res);
      int b;
      b = calc_b(cfg_k(g));
      for (int bb = 0; bb < b; bb++) begin
         mem[g][30 + b * idx + bb] <= cw[8*bb +: 8];
         mem[g][b * idx + bb]      <= 8'hEE;
         exp_mem[g][b * idx + bb]   = res[8*bb +: 8];
      end
   endtask

   // Cycle 1 is the edge that samples start; returns the cycle at which done is seen high.
   task automatic run(input int g, input int poke_at, output int cycles);
      @(negedge clk);
      start[g] = 1'b1;
      @(posedge clk);
      #1;
      start[g] = 1'b0;
      cycles = 1;
      check("start_clears_done", done[g], 0);
      check("start_sets_busy", busy[g], 1);
      check("start_clears_n_single", ns[g], 0);
      check("start_clears_n_double", nd[g], 0);
      while (!done[g] && cycles < 2000) begin
         if (cycles == poke_at) start[g] = 1'b1;
         @(posedge clk);
         #1;
         start[g] = 1'b0;
         cycles++;
      end
      check("done_drops_busy", busy[g], 0);
   endtask

   task automatic check_results(input int g);
      int nbytes;
      nbytes = calc_b(cfg_k(g)) * cfg_nw(g);
      for (int i = 0; i < nbytes; i++) check("result_byte", mem[g][i], exp_mem[g][i]);
   endtask

   // Every cycle: strobes exclusive, reads/writes in their regions, written bytes as modelled.
   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (rd_en[g] || wr_en[g]) check("rd_wr_exclusive", rd_en[g] & wr_en[g], 0);
         if (rd_en[g])
            check("rd_addr_in_src", (addr[g] >= 30) && (addr[g] < 30 + calc_b(cfg_k(g)) * cfg_nw(g)), 1);
         if (wr_en[g]) begin
            if (allow_wr[g]) begin
               check("wr_addr_in_dst", addr[g] < calc_b(cfg_k(g)) * cfg_nw(g), 1);
               check("wr_data", wdata[g], exp_mem[g][addr[g]]);
            end else begin
               check("no_write_after_reset", wr_en[g], 0);
            end
         end
      end
   end

   logic [63:0] t_mask [4] = '{64'h0, 64'h200, 64'h1, 64'h208};
   int          t_flip [4] = '{0, 1, 1, 2};
   logic [7:0]  t_lo   [4] = '{8'hA3, 8'hA3, 8'hA3, 8'hB2};
   logic [7:0]  t_hi   [4] = '{8'h05, 8'h45, 8'h45, 8'h85};

   initial begin
      int          cyc, k, n, p1, p2, exp_ns, exp_nd, w;
      logic [63:0] d, cw, res;

      for (int g = 0; g < 3; g++) begin
         rst[g]      = 1'b1;
         start[g]    = 1'b0;
         allow_wr[g] = 1'b1;
         for (int a = 0; a < 256; a++) begin
            mem[g][a]     <= 8'h00;
            exp_mem[g][a]  = 8'h00;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         check("rst_busy", busy[g], 0);
         check("rst_done", done[g], 0);
         check("rst_rd_en", rd_en[g], 0);
         check("rst_wr_en", wr_en[g], 0);
         check("rst_addr", addr[g], 0);
         check("rst_wdata", wdata[g], 0);
         check("rst_n_single", ns[g], 0);
         check("rst_n_double", nd[g], 0);
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) rst[g] = 1'b0;

      // Single-word K=11 cases: clean, data bit 9 flipped, p0 flipped, bits 9+3 flipped.
      for (int t = 0; t < 4; t++) begin
         cw  = encode(64'h5A3, 11) ^ t_mask[t];
         res = expect_result(64'h5A3, cw, t_flip[t], 11);
         load_word(0, 0, cw, res);
         run(0, -1, cyc);
         check("t_done_cycle", cyc, 6);
         check("t_result_lo", mem[0][0], t_lo[t]);
         check("t_result_hi", mem[0][1], t_hi[t]);
         check("t_n_single", ns[0], (t_flip[t] == 1) ? 1 : 0);
         check("t_n_double", nd[0], (t_flip[t] == 2) ? 1 : 0);
      end

      // Full K=11 run and K=26 run with 0/1/2 flips cycling per word.
      for (int g = 1; g < 3; g++) begin
         k = cfg_k(g);
         n = calc_n(k);
         exp_ns = 0;
         exp_nd = 0;
         for (int i = 0; i < cfg_nw(g); i++) begin
            d  = {$urandom, $urandom} & ((64'd1 << k) - 64'd1);
            cw = encode(d, k);
            p1 = $urandom_range(n - 1, 0);
            p2 = $urandom_range(n - 1, 0);
            while (p2 == p1) p2 = $urandom_range(n - 1, 0);
            if (i % 3 >= 1) begin
               cw[p1] = ~cw[p1];
               if (i % 3 == 1) exp_ns++;
            end
            if (i % 3 == 2) begin
               cw[p2] = ~cw[p2];
               exp_nd++;
            end
            load_word(g, i, cw, expect_result(d, cw, i % 3, k));
         end
         run(g, (g == 1) ? 30 : -1, cyc);
         w = 1 + cfg_nw(g) * (2 * calc_b(k) + 1);
         check("run_done_cycle", cyc, w);
         check("run_n_single", ns[g], exp_ns);
         check("run_n_double", nd[g], exp_nd);
         check_results(g);
      end
      check("k26_flags_w0", mem[2][3] & 8'hC0, 8'h00);
      check("k26_flags_w1", mem[2][7] & 8'hC0, 8'h40);
      check("k26_flags_w2", mem[2][11] & 8'hC0, 8'h80);

      // Restart from DONE after wiping the results: identical output expected.
      for (int a = 0; a < 30; a++) mem[1][a] <= 8'hEE;
      run(1, -1, cyc);
      check("rerun_done_cycle", cyc, 76);
      check("rerun_n_single", ns[1], 5);
      check("rerun_n_double", nd[1], 5);
      check_results(1);

      // Reset in the middle of a write burst.
      @(negedge clk);
      start[1] = 1'b1;
      @(posedge clk);
      #1;
      start[1] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      cyc = 0;
      while (!wr_en[1] && cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("midrun_write_seen", wr_en[1], 1);
      #1;
      allow_wr[1] = 1'b0;
      rst[1] = 1'b1;
      #1;
      check("midrun_rst_busy", busy[1], 0);
      check("midrun_rst_wr_en", wr_en[1], 0);
      check("midrun_rst_n_single", ns[1], 0);
      check("midrun_rst_n_double", nd[1], 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[1] = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("post_rst_idle_busy", busy[1], 0);
      check("post_rst_idle_done", done[1], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/secded_mem_engine.md
Name: secded_mem_engine

Overview:
- Hardware SECDED (extended Hamming) decode engine that takes over the data-memory task currently done in software by program 2.
- When started, it walks NUM_WORDS codewords stored little-endian in byte-wide data memory at SRC_BASE.
- For each codeword it classifies errors (none / single / double), corrects single-bit errors and writes a status-flagged data word to DST_BASE.
- It generalises program 2's fixed 11-bit/16-bit format to any data width K, and adds error counters and a restartable start/done handshake.

Parameters:
- K, 11: data bits per word (4..57). Derived: R = smallest r with 2^r >= K+r+1; N = K+R+1 codeword bits; BYTES = ceil(N/8).
- NUM_WORDS, 15: codewords processed per run (1..255).
- SRC_BASE, 30: byte address of codeword 0 low byte. Word i occupies SRC_BASE+BYTES*i and upward.
- DST_BASE, 0: byte address of result 0 low byte. Result i occupies DST_BASE+BYTES*i and upward.
- ADDR_W, 8: memory address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a run.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start or reset.
- mem_addr  out  ADDR_W  byte address.
- mem_rd_en  out  1  read strobe; data is returned on mem_rdata the following cycle.
- mem_rdata  in  8  read data.
- mem_wr_en  out  1  write strobe; memory writes mem_wdata at mem_addr on this edge.
- mem_wdata  out  8  write data.
- n_single  out  8  count of single-error words in the last or current run.
- n_double  out  8  count of double-error words in the last or current run.

Behaviour:
- Reset (async): state IDLE; busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, n_single, n_double, word index and byte counters all 0. Memory contents already written are kept.
- Codeword layout: bit 0 = overall parity p0. Bits at positions 2^j (1, 2, 4, ...) = Hamming parity. Remaining positions 3, 5, 6, 7, 9, ... carry d1..dK in ascending order. For K=11 this is {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}. Bits at or above N in the top byte are ignored.
- Syndrome: s = XOR of the indices i (1..N-1) whose bit is 1; q = XOR of all N bits.
- Classification:
  - s=0, q=0: no error.
  - q=1, s<N: single error; flip bit s (s=0 means p0 flipped, data unchanged).
  - q=1, s>=N: double error.
  - q=0, s!=0: double error.
- Result word (8*BYTES bits): bit[8*BYTES-1] = double flag; bit[8*BYTES-2] = single flag; bits[K-1:0] = corrected data; all other bits 0. On a double error the data field holds the raw extracted data bits, uncorrected.
- FSM: IDLE -> RD -> DEC -> WR -> (RD for the next word | DONE).
  - IDLE/DONE: start=1 clears done, n_single and n_double, sets word index 0 and busy, and goes to RD.
  - RD: BYTES cycles issuing mem_rd_en at consecutive addresses. Each byte is captured the cycle after its address is issued; the last byte is captured on the first DEC cycle.
  - DEC: 1 cycle; computes and registers the result word and increments the matching counter (counters saturate at 255).
  - WR: BYTES cycles with mem_wr_en=1, low byte first, at consecutive addresses.
  - After the last word: DONE, with busy=0 and done=1.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Latency: 2*BYTES+1 cycles per word. The DONE state is entered exactly 1 + NUM_WORDS*(2*BYTES+1) cycles after the start edge (K=11, NUM_WORDS=15: 76).
- start while busy: ignored.
- Overlapping src/dst regions: writes for word i never precede reads for word i. Other overlap is the caller's responsibility.
- Reset mid-run: immediate IDLE; a partially written word may remain in memory.

Test Plan:
- No error: K=11, bytes 0x2D@30, 0xB4@31 (d=0x5A3), NUM_WORDS=1, start -> mem[0]=0xA3, mem[1]=0x05, n_single=0, n_double=0; done rises 6 cycles after the start edge.
- Single data error: codeword 0xB62D (bit 9 flipped) -> mem[0]=0xA3, mem[1]=0x45, n_single=1. Codeword 0xB42C (p0 flipped) -> the same result.
- Double error: codeword 0xB625 (bits 9 and 3 flipped) -> mem[1][7]=1, mem[1][6]=0, n_double=1.
- Full run: 15 random words with mixed 0/1/2 flips as in program 2 -> every result matches the golden model, counters match the injected mix, done rises at cycle 76.
- Handshake: start pulse while busy is ignored (still done at cycle 76). start while done clears done and the counters and rerun results are identical. reset asserted mid-run drops busy, mem_wr_en and counters to 0 asynchronously, and no further memory writes occur.
- Width generalisation: K=26 (BYTES=4), 4 words -> results show the flags at bits 31/30, and done appears at 1+4*9=37 cycles.
